// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one fixed-latency data memory
// between the core load/store unit and the debug/program-loader port.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_req,
  input  logic                     core_we,
  input  logic [ADDR_W-1:0]        core_addr,
  input  logic [31:0]              core_wdata,
  input  logic [3:0]               core_wstrb,
  output logic                     core_ack,
  output logic [31:0]              core_rdata,
  output logic                     core_err,
  output logic                     core_stall,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [ADDR_W-1:0]        dbg_addr,
  input  logic [31:0]              dbg_wdata,
  input  logic [3:0]               dbg_wstrb,
  input  logic                     dbg_lock,
  output logic                     dbg_ack,
  output logic [31:0]              dbg_rdata,
  output logic                     dbg_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic [31:0]              mem_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    cnt_q, cnt_d;
  logic          last_dbg_q, last_dbg_d;
  logic          lock_q, lock_d;
  logic          we_q, we_d;

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;

  logic          core_ack_q, core_ack_d;
  logic [31:0]   core_rdata_q, core_rdata_d;
  logic          core_err_q, core_err_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;
  logic          dbg_err_q, dbg_err_d;

  logic              core_ok;
  logic              any_req;
  logic              pick_dbg;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;
  logic              sel_bad;

  // A held lock makes dbg the only eligible requester.
  always_comb begin
    core_ok   = core_req & ~lock_q;
    any_req   = core_ok | dbg_req;
    pick_dbg  = dbg_req & (~core_ok | ~last_dbg_q);
    sel_we    = pick_dbg ? dbg_we    : core_we;
    sel_addr  = pick_dbg ? dbg_addr  : core_addr;
    sel_wdata = pick_dbg ? dbg_wdata : core_wdata;
    sel_wstrb = pick_dbg ? dbg_wstrb : core_wstrb;
    sel_bad   = (sel_addr[1:0] != 2'b00) ||
                (sel_addr[ADDR_W-1:2] >= DEPTH_W);
  end

  logic        resp_go;
  logic        resp_err;
  logic [31:0] resp_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dbg_d  = last_dbg_q;
    lock_d      = lock_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_wstrb_d = '0;
    resp_go     = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          last_dbg_d = pick_dbg;
          lock_d     = lock_q | (pick_dbg & dbg_lock);
          we_d       = sel_we;
          if (sel_bad) begin
            state_d  = S_RESP;
            resp_go  = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_addr_d  = sel_addr[2 +: AW];
            mem_wdata_d = sel_wdata;
            mem_wstrb_d = sel_wstrb;
          end
        end else if (!dbg_lock && !dbg_req) begin
          lock_d = 1'b0;
        end
      end
      S_ISSUE: begin
        cnt_d   = 3'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d   = S_RESP;
          resp_go   = 1'b1;
          resp_data = we_q ? 32'h0 : mem_rdata;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (!dbg_lock) lock_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Steer the response to whichever port owns the current slot.
  always_comb begin
    core_ack_d   = 1'b0;
    core_rdata_d = '0;
    core_err_d   = 1'b0;
    dbg_ack_d    = 1'b0;
    dbg_rdata_d  = '0;
    dbg_err_d    = 1'b0;
    unique case (1'b1)
      resp_go & last_dbg_d: begin
        dbg_ack_d   = 1'b1;
        dbg_rdata_d = resp_data;
        dbg_err_d   = resp_err;
      end
      resp_go & ~last_dbg_d: begin
        core_ack_d   = 1'b1;
        core_rdata_d = resp_data;
        core_err_d   = resp_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_dbg_q   <= 1'b1;
      lock_q       <= 1'b0;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      core_ack_q   <= 1'b0;
      core_rdata_q <= '0;
      core_err_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_dbg_q   <= last_dbg_d;
      lock_q       <= lock_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      core_ack_q   <= core_ack_d;
      core_rdata_q <= core_rdata_d;
      core_err_q   <= core_err_d;
      dbg_ack_q    <= dbg_ack_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_err_q    <= dbg_err_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign core_ack   = core_ack_q;
  assign core_rdata = core_rdata_q;
  assign core_err   = core_err_q;
  assign dbg_ack    = dbg_ack_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_err    = dbg_err_q;
  assign core_stall = core_req & ~core_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a transaction-level
// reference model and a latency-accurate memory beside the DUT.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam bit P_CORE = 1'b0;
  localparam bit P_DBG  = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_ack, core_err, core_stall;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [3:0]  dbg_wstrb;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb),
    .core_ack(core_ack), .core_rdata(core_rdata), .core_err(core_err),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb), .dbg_lock(dbg_lock),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Memory device: read data appears LAT edges after the sampling edge.
  bit [31:0] env_mem [DEPTH];
  bit [31:0] rd_pipe [LAT];
  bit        preload;
  int        mem_en_cnt;
  logic [7:0] last_mem_addr;

  always @(posedge clk) begin
    if (preload) env_mem[5] <= 32'hDEADBEEF;
    if (mem_en) begin
      rd_pipe[0]    <= env_mem[mem_addr];
      mem_en_cnt    <= mem_en_cnt + 1;
      last_mem_addr <= mem_addr;
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_wstrb[b])
          env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  wstrb;
  } op_t;

  typedef struct {
    bit        port;
    bit [31:0] rdata;
    bit        err;
  } exp_t;

  bit [31:0] ref_mem [DEPTH];
  bit        last_dbg_m;
  exp_t      q[$];
  int        total = 0;
  int        bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit is_err(bit [31:0] addr);
    return (addr % 4 != 0) || (addr / 4 >= DEPTH);
  endfunction

  function automatic int lat_of(op_t op);
    return is_err(op.addr) ? 1 : LAT + 2;
  endfunction

  function automatic op_t mk(bit we, bit [31:0] addr, bit [31:0] wdata,
                             bit [3:0] wstrb);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wdata; o.wstrb = wstrb;
    return o;
  endfunction

  function automatic void predict(bit port, op_t op);
    exp_t e;
    int unsigned w;
    w = op.addr / 4;
    e.port  = port;
    e.err   = is_err(op.addr);
    e.rdata = 0;
    if (!e.err) begin
      if (op.we) begin
        for (int b = 0; b < 4; b++)
          if (op.wstrb[b]) ref_mem[w][8*b +: 8] = op.wdata[8*b +: 8];
      end else begin
        e.rdata = ref_mem[w];
      end
    end
    q.push_back(e);
    last_dbg_m = port;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  w;
    w = $urandom_range(0, 15);
    case ($urandom_range(0, 9))
      0: o.addr = 32'(w * 4 + $urandom_range(1, 3));
      1: o.addr = 32'((DEPTH + $urandom_range(0, 1000)) * 4);
      2: o.addr = 32'((DEPTH - 1) * 4);
      default: o.addr = 32'(w * 4);
    endcase
    o.we    = 1'($urandom_range(0, 1));
    o.wdata = $urandom;
    o.wstrb = 4'($urandom_range(0, 15));
    return o;
  endfunction

  task automatic drive(input bit port, input op_t op, input bit lk,
                       input bit lk_after, output int lat);
    bit acked;
    acked = 0;
    lat = 0;
    @(negedge clk);
    if (port == P_DBG) begin
      dbg_we = op.we; dbg_addr = op.addr;
      dbg_wdata = op.wdata; dbg_wstrb = op.wstrb;
      dbg_lock = lk; dbg_req = 1'b1;
    end else begin
      core_we = op.we; core_addr = op.addr;
      core_wdata = op.wdata; core_wstrb = op.wstrb;
      core_req = 1'b1;
    end
    for (int i = 0; i < 400 && !acked; i++) begin
      @(negedge clk);
      lat++;
      if (port == P_DBG) begin
        if (dbg_ack) begin
          acked = 1; dbg_req = 1'b0; dbg_lock = lk_after;
        end
      end else if (core_ack) begin
        chk("core_stall_at_ack", 32'(core_stall), 32'd0);
        acked = 1; core_req = 1'b0;
      end else begin
        chk("core_stall_pending", 32'(core_stall), 32'd1);
      end
    end
    if (!acked) chk("ack_timeout", 32'(acked), 32'd1);
  endtask

  task automatic do_round(input bit uc, input bit ud, input op_t oc,
                          input op_t od);
    int lc, ld, ec, ed;
    ec = lat_of(oc);
    ed = lat_of(od);
    if (uc && ud) begin
      if (last_dbg_m) begin
        predict(P_CORE, oc); predict(P_DBG, od);
        ed = ec + 1 + ed;
      end else begin
        predict(P_DBG, od); predict(P_CORE, oc);
        ec = ed + 1 + ec;
      end
    end else if (uc) begin
      predict(P_CORE, oc);
    end else if (ud) begin
      predict(P_DBG, od);
    end
    fork
      begin
        if (uc) begin
          drive(P_CORE, oc, 1'b0, 1'b0, lc);
          chk("core_latency", 32'(lc), 32'(ec));
        end
      end
      begin
        if (ud) begin
          drive(P_DBG, od, 1'b0, 1'b0, ld);
          chk("dbg_latency", 32'(ld), 32'(ed));
        end
      end
    join
  endtask

  initial begin
    int   lat, c0;
    exp_t e;
    bit   uc, ud;
    int   mode;
    rst = 1'b1;
    preload = 1'b1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_wstrb = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_wstrb = 0;
    dbg_lock = 0;
    ref_mem[5] = 32'hDEADBEEF;
    last_dbg_m = P_DBG;

    fork
      forever begin
        @(negedge clk);
        if (core_ack || dbg_ack) begin
          chk("dual_ack", 32'(core_ack & dbg_ack), 32'd0);
          chk("ack_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("ack_port", 32'(dbg_ack), 32'(e.port));
            chk("rdata", dbg_ack ? dbg_rdata : core_rdata, e.rdata);
            chk("err", 32'(dbg_ack ? dbg_err : core_err), 32'(e.err));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    preload = 1'b0;
    chk("rst_ctl", 32'({core_ack, dbg_ack, mem_en, mem_we, core_err,
                        dbg_err, core_stall}), 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_mem_bus", 32'({mem_addr, mem_wstrb}), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Simultaneous pairs right after reset: core, dbg, core, dbg.
    do_round(1, 1, mk(0, 32'h14, 0, 0), mk(0, 32'h18, 0, 0));
    do_round(1, 1, mk(1, 32'h20, 32'h12345678, 4'hF), mk(0, 32'h20, 0, 0));

    c0 = mem_en_cnt;
    predict(P_CORE, mk(0, 32'h14, 0, 0));
    drive(P_CORE, mk(0, 32'h14, 0, 0), 0, 0, lat);
    chk("load_latency", 32'(lat), 32'(LAT + 2));
    chk("load_mem_en_count", 32'(mem_en_cnt - c0), 32'd1);
    chk("load_mem_addr", 32'(last_mem_addr), 32'd5);

    // Locked dbg burst while core waits.
    for (int i = 0; i < 4; i++)
      predict(P_DBG, mk(1, 32'(i * 4), 32'(i + 1), 4'hF));
    predict(P_CORE, mk(0, 32'h8, 0, 0));
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          drive(P_DBG, mk(1, 32'(i * 4), 32'(i + 1), 4'hF), 1'b1,
                (i != 3), lat);
          chk("lock_dbg_latency", 32'(lat), 32'(LAT + 2));
        end
      end
      begin
        int lc;
        @(negedge clk);
        drive(P_CORE, mk(0, 32'h8, 0, 0), 0, 0, lc);
      end
    join
    for (int i = 0; i < 4; i++)
      chk("lock_burst_mem", env_mem[i], 32'(i + 1));

    c0 = mem_en_cnt;
    predict(P_CORE, mk(0, 32'h13, 0, 0));
    drive(P_CORE, mk(0, 32'h13, 0, 0), 0, 0, lat);
    chk("misaligned_latency", 32'(lat), 32'd1);
    predict(P_CORE, mk(0, 32'h400, 0, 0));
    drive(P_CORE, mk(0, 32'h400, 0, 0), 0, 0, lat);
    chk("out_of_range_latency", 32'(lat), 32'd1);
    repeat (2) @(negedge clk);
    chk("error_no_mem_en", 32'(mem_en_cnt - c0), 32'd0);

    predict(P_CORE, mk(1, 32'h1C, 32'hA5A5A5A5, 4'b0011));
    drive(P_CORE, mk(1, 32'h1C, 32'hA5A5A5A5, 4'b0011), 0, 0, lat);
    chk("strb_store_latency", 32'(lat), 32'(LAT + 2));
    predict(P_CORE, mk(0, 32'h1C, 0, 0));
    drive(P_CORE, mk(0, 32'h1C, 0, 0), 0, 0, lat);
    chk("strb_load_latency", 32'(lat), 32'(LAT + 2));

    // Reset while the access is being issued.
    @(negedge clk);
    core_we = 0; core_addr = 32'h0C; core_wstrb = 0; core_req = 1'b1;
    @(negedge clk);
    chk("mid_issue_mem_en", 32'(mem_en), 32'd1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_async_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("mid_rst_no_ack", 32'(core_ack), 32'd0);
    chk("mid_rst_stall", 32'(core_stall), 32'd1);
    core_req = 1'b0;
    rst = 1'b0;
    last_dbg_m = P_DBG;
    predict(P_CORE, mk(0, 32'h14, 0, 0));
    drive(P_CORE, mk(0, 32'h14, 0, 0), 0, 0, lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT + 2));

    for (int r = 0; r < 80; r++) begin
      mode = $urandom_range(0, 2);
      uc = (mode != 1);
      ud = (mode != 0);
      do_round(uc, ud, rand_op(), rand_op());
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
